// File: rtl/half_adder.sv
// Registered unsigned adder tile for the CGRA datapath.
// Outputs are a pure registered function of the inputs sampled at the last clock edge.
module half_adder #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             on_off,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] c,
   output logic             carry_out,
   output logic             ack
);

   logic [width:0] full_sum;

   // Zero-extend both operands so the top bit of the sum is the carry.
   assign full_sum = {1'b0, a} + {1'b0, b};

   always_ff @(posedge clk) begin
      if (!reset) begin
         c         <= '0;
         carry_out <= 1'b0;
         ack       <= 1'b0;
      end else if (!on_off) begin
         c         <= '0;
         carry_out <= 1'b0;
         ack       <= 1'b0;
      end else begin
         c         <= full_sum[width-1:0];
         carry_out <= full_sum[width];
         ack       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: vector table, hand-written toggle sequences and
// random operands, all checked through a scoreboard queue of expected results.
module tb_half_adder;

   localparam int width = 16;

   typedef struct packed {
      logic             rst_n;
      logic             en;
      logic [width-1:0] op_a;
      logic [width-1:0] op_b;
      logic [width-1:0] exp_c;
      logic             exp_carry;
      logic             exp_ack;
   } vec_t;

   typedef struct packed {
      logic [width-1:0] c;
      logic             carry;
      logic             ack;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             on_off;
   logic [width-1:0] a;
   logic [width-1:0] b;
   logic [width-1:0] c;
   logic             carry_out;
   logic             ack;

   int   check_count;
   int   error_count;
   exp_t scoreboard[$];
   vec_t vectors[9];

   half_adder #(.width(width)) dut (
      .clk       (clk),
      .reset     (reset),
      .on_off    (on_off),
      .a         (a),
      .b         (b),
      .c         (c),
      .carry_out (carry_out),
      .ack       (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs on the falling edge and queue what the next edge must produce.
   task automatic applyStimulus(input logic rst_n, input logic en,
                                input logic [width-1:0] op_a, input logic [width-1:0] op_b,
                                input logic [width-1:0] exp_c, input logic exp_carry,
                                input logic exp_ack);
      exp_t e;
      @(negedge clk);
      reset  = rst_n;
      on_off = en;
      a      = op_a;
      b      = op_b;
      e.c     = exp_c;
      e.carry = exp_carry;
      e.ack   = exp_ack;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      check_count++;
      if (scoreboard.size() == 0) begin
         error_count++;
         $display("[TB] FAIL %s: scoreboard empty, got c=%h carry=%b ack=%b", name, c, carry_out, ack);
      end else begin
         e = scoreboard.pop_front();
         if (c !== e.c || carry_out !== e.carry || ack !== e.ack) begin
            error_count++;
            $display("[TB] FAIL %s: got c=%h carry=%b ack=%b, expected c=%h carry=%b ack=%b",
                     name, c, carry_out, ack, e.c, e.carry, e.ack);
         end
      end
   endtask

   task automatic runStep(input string name, input logic rst_n, input logic en,
                          input logic [width-1:0] op_a, input logic [width-1:0] op_b,
                          input logic [width-1:0] exp_c, input logic exp_carry,
                          input logic exp_ack);
      applyStimulus(rst_n, en, op_a, op_b, exp_c, exp_carry, exp_ack);
      checkOutput(name);
   endtask

   initial begin
      logic [width:0]   model_sum;
      logic [width-1:0] ra;
      logic [width-1:0] rb;
      logic             ren;

      check_count = 0;
      error_count = 0;
      reset  = 1'b0;
      on_off = 1'b1;
      a      = 16'h1234;
      b      = 16'h5678;

      vectors[0] = '{1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0};
      vectors[1] = '{1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0};
      vectors[2] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0};
      vectors[3] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b1};
      vectors[4] = '{1'b1, 1'b1, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1};
      vectors[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vectors[6] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vectors[7] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      vectors[8] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b1};

      for (int i = 0; i < 9; i++) begin
         runStep($sformatf("vector%0d", i), vectors[i].rst_n, vectors[i].en,
                 vectors[i].op_a, vectors[i].op_b,
                 vectors[i].exp_c, vectors[i].exp_carry, vectors[i].exp_ack);
      end

      // Enable toggling around a valid result.
      runStep("toggle_valid",   1'b1, 1'b1, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b1);
      runStep("toggle_off",     1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);
      runStep("toggle_off_hold",1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
      runStep("toggle_on",      1'b1, 1'b1, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b1);
      runStep("toggle_stream",  1'b1, 1'b1, 16'h0100, 16'h0023, 16'h0123, 1'b0, 1'b1);

      // One-edge reset pulse mid-stream, with on_off still high.
      runStep("reset_pulse",    1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
      runStep("reset_release",  1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b1);
      runStep("reset_resume",   1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         ra  = width'($urandom);
         rb  = width'($urandom);
         ren = ($urandom_range(0, 3) != 0);
         model_sum = {1'b0, ra} + {1'b0, rb};
         if (ren)
            runStep($sformatf("random%0d", i), 1'b1, 1'b1, ra, rb,
                    model_sum[width-1:0], model_sum[width], 1'b1);
         else
            runStep($sformatf("random%0d", i), 1'b1, 1'b0, ra, rb, 16'h0000, 1'b0, 1'b0);
      end

      check_count++;
      if (scoreboard.size() != 0) begin
         error_count++;
         $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", scoreboard.size());
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
